// File: rtl/group_serial_subtractor.sv
// -----------------------------------------------------------------------------
// group_serial_subtractor
//
// Multi-cycle subtractor: result = a - b - bin, computed one GROUPSIZE-bit
// group per clock through a registered borrow. Used on the SUB/SLTU path where
// latency is cheaper than a full-width carry chain.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            synchronous active-low reset
//   in_valid   in   1            operands a/b/bin valid
//   in_ready   out  1            block can accept operands (IDLE only)
//   a          in   INPUTSIZE    minuend
//   b          in   INPUTSIZE    subtrahend
//   bin        in   1            borrow in
//   out_valid  out  1            result valid (DONE only)
//   out_ready  in   1            consumer accepts result
//   result     out  INPUTSIZE+1  [n-1:0] difference mod 2^n, [n] borrow out
//   overflow   out  1            two's-complement signed overflow
//
// State table
//   S_IDLE | waiting for operands, in_ready=1
//   S_RUN  | one group per edge, r_cnt = group being computed
//   S_DONE | result presented, out_valid=1, held until out_ready
// -----------------------------------------------------------------------------
module group_serial_subtractor #(
    parameter int INPUTSIZE = 64,
    parameter int GROUPSIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INPUTSIZE-1:0] a,
    input  logic [INPUTSIZE-1:0] b,
    input  logic                 bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INPUTSIZE:0]   result,
    output logic                 overflow
);

    localparam int NG = INPUTSIZE / GROUPSIZE;
    localparam int CW = (NG > 1) ? $clog2(NG) : 1;

    generate
        if (INPUTSIZE % GROUPSIZE != 0) begin : g_bad_width
            $fatal(1, "INPUTSIZE must be a multiple of GROUPSIZE");
        end
        if (!(GROUPSIZE == 1 || GROUPSIZE == 2 || GROUPSIZE == 4 || GROUPSIZE == 8)) begin : g_bad_group
            $fatal(1, "GROUPSIZE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   r_borrow;
    logic                   w_borrow_nxt;
    logic [INPUTSIZE-1:0]   r_a;
    logic [INPUTSIZE-1:0]   w_a_nxt;
    logic [INPUTSIZE-1:0]   r_b;
    logic [INPUTSIZE-1:0]   w_b_nxt;
    logic [INPUTSIZE-1:0]   r_res;
    logic [INPUTSIZE-1:0]   w_res_nxt;
    logic                   r_bout;
    logic                   w_bout_nxt;
    logic                   r_ovf;
    logic                   w_ovf_nxt;

    // Operands are shifted right one group per cycle, so the group being
    // worked on is always the low slice; no wide read mux is needed.
    logic [GROUPSIZE-1:0]   w_a_grp;
    logic [GROUPSIZE-1:0]   w_b_grp;
    logic [GROUPSIZE:0]     w_diff;
    logic [GROUPSIZE-1:0]   w_d;
    logic                   w_bout;
    logic                   w_last;
    logic [INPUTSIZE-1:0]   w_res_shift;

    assign w_a_grp = r_a[GROUPSIZE-1:0];
    assign w_b_grp = r_b[GROUPSIZE-1:0];
    assign w_diff  = {1'b0, w_a_grp} - {1'b0, w_b_grp} - {{GROUPSIZE{1'b0}}, r_borrow};
    assign w_d     = w_diff[GROUPSIZE-1:0];
    assign w_bout  = w_diff[GROUPSIZE];
    assign w_last  = (r_cnt == CW'(NG - 1));

    // Each new group enters at the top of the result and walks down; after
    // NG steps group 0 sits in the low bits.
    assign w_res_shift = (r_res >> GROUPSIZE) | (INPUTSIZE'(w_d) << (INPUTSIZE - GROUPSIZE));

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = {r_bout, r_res};
    assign overflow  = r_ovf;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_borrow_nxt = r_borrow;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_res_nxt    = r_res;
        w_bout_nxt   = r_bout;
        w_ovf_nxt    = r_ovf;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_nxt      = a;
                    w_b_nxt      = b;
                    w_borrow_nxt = bin;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                w_a_nxt      = r_a >> GROUPSIZE;
                w_b_nxt      = r_b >> GROUPSIZE;
                w_res_nxt    = w_res_shift;
                w_borrow_nxt = w_bout;
                w_cnt_nxt    = r_cnt + CW'(1);
                if (w_last) begin
                    // On the last step the low slices hold the original top
                    // group, so their MSBs are the operand sign bits.
                    w_bout_nxt  = w_bout;
                    w_ovf_nxt   = (w_a_grp[GROUPSIZE-1] ^ w_b_grp[GROUPSIZE-1]) &
                                  (w_a_grp[GROUPSIZE-1] ^ w_d[GROUPSIZE-1]);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_borrow <= w_borrow_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_res    <= w_res_nxt;
            r_bout   <= w_bout_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

endmodule

// File: tb/tb_group_serial_subtractor.sv
module tb_group_serial_subtractor;

    localparam int N  = 64;
    localparam int G  = 8;
    localparam int NG = N / G;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          bin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N:0]    result;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    group_serial_subtractor #(.INPUTSIZE(N), .GROUPSIZE(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N:0] got, input logic [N:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference arithmetic: plain wide subtraction.
    function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
    endfunction

    // Signed overflow: the exact signed difference does not fit in N bits.
    function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
        logic [N+1:0] s;
        s = {{2{x[N-1]}}, x} - {{2{y[N-1]}}, y} - {{(N+1){1'b0}}, bi};
        return s[N] != s[N-1];
    endfunction

    // Transaction-level model: a pending result becomes visible NG edges
    // after acceptance and leaves on out_ready.
    bit         m_init = 0;
    bit         m_pend = 0;
    bit         m_zero = 0;
    int         m_cnt  = 0;
    logic [N:0] m_res  = '0;
    logic       m_ovf  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 1;
            m_pend = 0;
            m_cnt  = 0;
            m_zero = 1;
        end else if (m_init) begin
            if (m_pend) begin
                if (m_cnt > 0) m_cnt--;
                else if (out_ready) m_pend = 0;
            end else if (in_valid) begin
                m_pend = 1;
                m_cnt  = NG;
                m_res  = ref_sub(a, b, bin);
                m_ovf  = ref_ovf(a, b, bin);
                m_zero = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", {{N{1'b0}}, in_ready}, {{N{1'b0}}, !m_pend});
            chk("out_valid", {{N{1'b0}}, out_valid}, {{N{1'b0}}, (m_pend && m_cnt == 0)});
            if (m_pend && m_cnt == 0) begin
                chk("result", result, m_res);
                chk("overflow", {{N{1'b0}}, overflow}, {{N{1'b0}}, m_ovf});
            end else if (m_zero) begin
                chk("result_rst", result, '0);
                chk("overflow_rst", {{N{1'b0}}, overflow}, '0);
            end
        end
    end

    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1");
        end
        a = x; b = y; bin = bi; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        bin = 1'($urandom_range(0, 1));
    endtask

    task automatic collect(input int hold, output int lat, output logic [N:0] r, output logic o);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL collect_timeout: out_valid got 0 expected 1");
        end
        r = result;
        o = overflow;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic bi, input logic [N:0] er, input logic eo, input int elat);
        int         lat;
        logic [N:0] r;
        logic       o;
        issue(x, y, bi);
        collect(0, lat, r, o);
        chk({name, "_res"}, r, er);
        chk({name, "_ovf"}, {{N{1'b0}}, o}, {{N{1'b0}}, eo});
        if (elat > 0) chk({name, "_lat"}, N'(lat), N'(elat));
    endtask

    function automatic logic [N-1:0] rand_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(N-1){1'b0}}};
            3: return N'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int         lat;
        logic [N:0] r;
        logic       o;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", {{N{1'b0}}, in_ready}, 65'd1);
        chk("reset_out_valid", {{N{1'b0}}, out_valid}, 65'd0);
        chk("reset_result", result, 65'd0);
        chk("reset_overflow", {{N{1'b0}}, overflow}, 65'd0);
        @(negedge clk);

        directed("t1", 64'd5, 64'd3, 1'b0, 65'd2, 1'b0, NG);
        directed("t2", 64'd0, 64'd1, 1'b0, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, 0);
        directed("t3", 64'h8000_0000_0000_0000, 64'd1, 1'b0, {1'b0, 64'h7FFF_FFFF_FFFF_FFFF}, 1'b1, 0);
        directed("t4", 64'h0000_0001_0000_0000, 64'd1, 1'b1, {1'b0, 64'h0000_0000_FFFF_FFFE}, 1'b0, 0);
        directed("wrap", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, {1'b1, 64'd0}, 1'b0, 0);

        // Hold in DONE while new operands are offered.
        issue(64'd100, 64'd58, 1'b1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_result", result, 65'h29);
            chk("hold_in_ready", {{N{1'b0}}, in_ready}, 65'd0);
            if (i == 1) begin
                a = 64'hDEAD; b = 64'h1; bin = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("hold_result_end", result, 65'h29);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_in_ready", {{N{1'b0}}, in_ready}, 65'd1);
        chk("release_out_valid", {{N{1'b0}}, out_valid}, 65'd0);

        // Reset in the middle of a run.
        issue(64'h1234_5678_9ABC_DEF0, 64'h1111, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_out_valid", {{N{1'b0}}, out_valid}, 65'd0);
        chk("abort_in_ready", {{N{1'b0}}, in_ready}, 65'd1);
        chk("abort_result", result, 65'd0);
        repeat (12) @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] x, y;
            logic         bi;
            x  = rand_op();
            y  = rand_op();
            bi = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(x, y, bi);
            collect($urandom_range(0, 3), lat, r, o);
            chk("rand_res", r, ref_sub(x, y, bi));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
